mem_rd_arbiter: RTL and testbench
=================================

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of read requesters (2..4).
REQ-002 Parameter SLV_ID_W, default 4: requester-side AXI ID width.
REQ-003 Parameter MAX_OUT, default 4: per-requester outstanding read-burst limit (1..15).
REQ-004 Parameter AGE_LIMIT, default 64: wait-cycle threshold for age promotion (used only when MEM_RD_ARB_AGE_EN is defined).
REQ-005 Derived MST_ID_W = SLV_ID_W + 2.
REQ-006 aclk  input  1  sole clock; all state on rising edge.
REQ-007 areset  input  1  reset; asynchronous, active-high (already decided).
REQ-008 s_ar_valid/s_ar_ready  in/out  NUM_REQ  per-requester AR handshake.
REQ-009 s_ar_id  input  NUM_REQ*SLV_ID_W  packed per-requester ARID.
REQ-010 s_ar_addr  input  NUM_REQ*32; s_ar_len  input  NUM_REQ*8; s_ar_size  input  NUM_REQ*3; s_ar_burst  input  NUM_REQ*2.
REQ-011 s_r_valid  output  NUM_REQ; s_r_ready  input  NUM_REQ; s_r_data 32, s_r_id SLV_ID_W, s_r_resp 2, s_r_last 1  outputs, shared by all requesters.
REQ-012 m_ar_* outputs (id MST_ID_W, addr 32, len 8, size 3, burst 2, valid), m_ar_ready input: memory-side AR.
REQ-013 m_r_* inputs (valid, id MST_ID_W, data 32, resp 2, last), m_r_ready output: memory-side R.
REQ-014 rid_err  output  1  one-cycle pulse on an R beat whose requester index >= NUM_REQ.

Function
REQ-015 AR path SHALL be a one-entry register slice: a grant loads the slot; m_ar_valid comes from the slot; latency s_ar handshake -> m_ar_valid = 1 cycle.
REQ-016 A grant SHALL occur only when the slot is empty or is being drained (m_ar_valid & m_ar_ready) in the same cycle.
REQ-017 Eligible = s_ar_valid[i] & (outstanding[i] < MAX_OUT); the winner receives s_ar_ready[i]=1 for exactly that cycle; all other s_ar_ready SHALL be 0.
REQ-018 Arbitration SHALL be round-robin: search starts at rr_ptr; after a grant to i, rr_ptr = (i+1) mod NUM_REQ; rr_ptr is unchanged when no grant occurs.
REQ-019 Slot SHALL hold m_ar_id = {i[1:0], s_ar_id[i]} and the winner's addr/len/size/burst, stable while m_ar_valid & !m_ar_ready.
REQ-020 outstanding[i] (4 bits) SHALL increment on an AR grant to i and decrement on m_r_valid & m_r_ready & m_r_last for index i; both in the same cycle leave it unchanged.
REQ-021 R routing SHALL be combinational: k = m_r_id[MST_ID_W-1 -: 2]; s_r_valid[k] = m_r_valid; m_r_ready = s_r_ready[k]; s_r_id = m_r_id[SLV_ID_W-1:0]; data/resp/last passed through.
REQ-022 When k >= NUM_REQ, the beat SHALL be sunk (m_r_ready=1, no s_r_valid asserted) and rid_err pulses once per beat.
REQ-023 A requester at MAX_OUT SHALL be skipped without blocking others; it becomes eligible the cycle after its outstanding count drops.

Reset
REQ-024 While areset=1: m_ar_valid=0, slot empty, all s_ar_ready=0, rr_ptr=0, all outstanding=0, all age counters=0, rid_err=0.
REQ-025 Reset asserted mid-burst SHALL discard slot contents and counts immediately; no AR is issued in the first cycle after release.

Configuration
REQ-026 Macro MEM_RD_ARB_AGE_EN defined: per-requester 8-bit age counter increments each cycle s_ar_valid[i] is high and ungranted, saturates at 255, clears on grant; any eligible requester with age >= AGE_LIMIT SHALL win over RR order (lowest index among aged); rr_ptr still updates per REQ-018.
REQ-027 Macro undefined: no age counters synthesized; pure round-robin.

Structure
REQ-028 Package mem_rd_arb_pkg SHALL hold ID-prefix width (2), MAX_OUT counter width, and the AR slot struct (id, addr, len, size, burst).
REQ-029 One sub-module, mem_rd_rr_pick: combinational eligible mask + rr_ptr (+ aged mask) -> one-hot grant.

Verification
REQ-030 Req0,1,2 valid continuously, m_ar_ready=1 -> grants 0,1,2,0,1,2; m_ar_id prefixes 0,1,2 in order, one per cycle.
REQ-031 Req1 issues 4 ARs (MAX_OUT=4), no R returned -> fifth s_ar_ready[1] stays 0 while req2 is granted; one r_last to req1 -> req1 granted next eligible cycle.
REQ-032 m_ar_ready held 0 for 5 cycles -> m_ar_id/addr stable, no s_ar_ready asserted; release -> slot drains and reloads same cycle.
REQ-033 m_r_id=6'b10_0011, len 3 burst, s_r_ready[2] toggling -> only s_r_valid[2], s_r_id=4'h3, outstanding[2] decrements once on last beat.
REQ-034 m_r_id=6'b11_0000 with NUM_REQ=3 -> m_r_ready=1, rid_err pulses, no s_r_valid.
REQ-035 AGE_EN, AGE_LIMIT=4, req0 and req1 hammer, req2 valid -> req2 granted within 5 cycles of its valid; areset pulse mid-test clears m_ar_valid asynchronously.

Source files
------------

// File: rtl/mem_rd_arb_pkg.sv
// Shared types and constants for the memory read arbiter.
// The arbiter prefixes each forwarded ARID with the requester index so
// read data can be routed back without any lookup table.
package mem_rd_arb_pkg;

  localparam int ID_PFX_W  = 2;   // requester index carried in the top ARID bits
  localparam int OUT_CNT_W = 4;   // per-requester outstanding-burst counter
  localparam int AGE_W     = 8;   // wait-cycle counter for age promotion
  localparam int SLOT_ID_W = 16;  // widest memory-side ARID the slot can carry

  typedef struct packed {
    logic [SLOT_ID_W-1:0] id;
    logic [31:0]          addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ar_slot_t;

  // one-hot (up to 4 requesters) to index
  function automatic logic [ID_PFX_W-1:0] oh_to_idx(input logic [3:0] oh);
    oh_to_idx = '0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) oh_to_idx = ID_PFX_W'(i);
  endfunction

endpackage

// File: rtl/mem_rd_rr_pick.sv
// Combinational grant picker: aged requesters (lowest index first) win,
// otherwise round-robin starting at rr_ptr. Output is one-hot or zero.
module mem_rd_rr_pick
  import mem_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]  eligible,
  input  logic [ID_PFX_W-1:0] rr_ptr,
  input  logic [NUM_REQ-1:0]  aged,
  output logic [NUM_REQ-1:0]  grant
);

  logic [NUM_REQ-1:0] aged_elig;
  assign aged_elig = eligible & aged;

  // descending loops so the last hit (lowest index / nearest rr_ptr) wins
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    if (|aged_elig) begin
      for (int i = NUM_REQ-1; i >= 0; i--)
        if (aged_elig[i]) grant = NUM_REQ'(1) << i;
    end else begin
      for (int o = NUM_REQ-1; o >= 0; o--) begin
        idx = (int'(rr_ptr) + o) % NUM_REQ;
        if (eligible[idx]) grant = NUM_REQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// N-to-1 AXI read-address arbiter with a one-entry AR slice and
// combinational read-data routing by ARID prefix.
// Optional feature: define MEM_RD_ARB_AGE_EN to add per-requester age
// counters that promote long-waiting requesters over round-robin order.
module mem_rd_arbiter
  import mem_rd_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 3,
  parameter  int SLV_ID_W  = 4,
  parameter  int MAX_OUT   = 4,
  parameter  int AGE_LIMIT = 64,
  localparam int MST_ID_W  = SLV_ID_W + ID_PFX_W
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [NUM_REQ-1:0]           s_ar_valid,
  output logic [NUM_REQ-1:0]           s_ar_ready,
  input  logic [NUM_REQ*SLV_ID_W-1:0]  s_ar_id,
  input  logic [NUM_REQ*32-1:0]        s_ar_addr,
  input  logic [NUM_REQ*8-1:0]         s_ar_len,
  input  logic [NUM_REQ*3-1:0]         s_ar_size,
  input  logic [NUM_REQ*2-1:0]         s_ar_burst,
  output logic [NUM_REQ-1:0]           s_r_valid,
  input  logic [NUM_REQ-1:0]           s_r_ready,
  output logic [31:0]                  s_r_data,
  output logic [SLV_ID_W-1:0]          s_r_id,
  output logic [1:0]                   s_r_resp,
  output logic                         s_r_last,
  output logic                         m_ar_valid,
  input  logic                         m_ar_ready,
  output logic [MST_ID_W-1:0]          m_ar_id,
  output logic [31:0]                  m_ar_addr,
  output logic [7:0]                   m_ar_len,
  output logic [2:0]                   m_ar_size,
  output logic [1:0]                   m_ar_burst,
  input  logic                         m_r_valid,
  output logic                         m_r_ready,
  input  logic [MST_ID_W-1:0]          m_r_id,
  input  logic [31:0]                  m_r_data,
  input  logic [1:0]                   m_r_resp,
  input  logic                         m_r_last,
  output logic                         rid_err
);

  ar_slot_t                          slot_q, slot_d;
  logic                              slot_vld, arb_en, can_load, grant_any, k_ok;
  logic [ID_PFX_W-1:0]               rr_ptr, gidx, k;
  logic [NUM_REQ-1:0]                eligible, aged, grant_oh, r_done;
  logic [NUM_REQ-1:0][OUT_CNT_W-1:0] outstanding;

  // arb_en holds off grants for the first cycle after reset release
  assign can_load   = arb_en & (~slot_vld | m_ar_ready);
  assign s_ar_ready = can_load ? grant_oh : '0;
  assign grant_any  = |s_ar_ready;
  assign gidx       = oh_to_idx(4'(grant_oh));

  // a requester at its outstanding limit drops out without blocking others
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = s_ar_valid[i] && (int'(outstanding[i]) < MAX_OUT);
  end

  mem_rd_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .aged     (aged),
    .grant    (grant_oh)
  );

  // winner's request tagged with its index in the top ARID bits
  always_comb begin
    slot_d       = '0;
    slot_d.id    = SLOT_ID_W'({gidx, s_ar_id[gidx*SLV_ID_W +: SLV_ID_W]});
    slot_d.addr  = s_ar_addr[gidx*32 +: 32];
    slot_d.len   = s_ar_len[gidx*8 +: 8];
    slot_d.size  = s_ar_size[gidx*3 +: 3];
    slot_d.burst = s_ar_burst[gidx*2 +: 2];
  end

  // one-entry AR slice: load on grant (also when draining), else drain
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      slot_vld <= 1'b0;
      slot_q   <= '0;
    end else if (grant_any) begin
      slot_vld <= 1'b1;
      slot_q   <= slot_d;
    end else if (m_ar_ready) begin
      slot_vld <= 1'b0;
    end

  assign m_ar_valid = slot_vld;
  assign m_ar_id    = slot_q.id[MST_ID_W-1:0];
  assign m_ar_addr  = slot_q.addr;
  assign m_ar_len   = slot_q.len;
  assign m_ar_size  = slot_q.size;
  assign m_ar_burst = slot_q.burst;

  logic unused_slot_id;
  assign unused_slot_id = ^slot_q.id[SLOT_ID_W-1:MST_ID_W];

  // round-robin pointer, post-reset enable and registered bad-ID pulse
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      rr_ptr  <= '0;
      arb_en  <= 1'b0;
      rid_err <= 1'b0;
    end else begin
      arb_en  <= 1'b1;
      rid_err <= m_r_valid & ~k_ok;
      if (grant_any)
        rr_ptr <= (int'(gidx) == NUM_REQ-1) ? '0 : gidx + 1'b1;
    end

  // R routing: unknown prefixes are sunk so the memory side never stalls
  assign k        = m_r_id[MST_ID_W-1 -: ID_PFX_W];
  assign s_r_id   = m_r_id[SLV_ID_W-1:0];
  assign s_r_data = m_r_data;
  assign s_r_resp = m_r_resp;
  assign s_r_last = m_r_last;

  always_comb begin
    s_r_valid = '0;
    m_r_ready = 1'b1;
    r_done    = '0;
    k_ok      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (int'(k) == i) begin
        k_ok         = 1'b1;
        s_r_valid[i] = m_r_valid;
        m_r_ready    = s_r_ready[i];
        r_done[i]    = m_r_valid & s_r_ready[i] & m_r_last;
      end
  end

  // outstanding bursts: +1 on AR grant, -1 on accepted last beat
  always_ff @(posedge aclk or posedge areset)
    if (areset) outstanding <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (s_ar_ready[i] && !r_done[i])      outstanding[i] <= outstanding[i] + 1'b1;
        else if (!s_ar_ready[i] && r_done[i]) outstanding[i] <= outstanding[i] - 1'b1;

`ifdef MEM_RD_ARB_AGE_EN
  logic [NUM_REQ-1:0][AGE_W-1:0] age;

  // saturating wait counters, cleared by a grant
  always_ff @(posedge aclk or posedge areset)
    if (areset) age <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (s_ar_ready[i])                        age[i] <= '0;
        else if (s_ar_valid[i] && age[i] != '1)   age[i] <= age[i] + 1'b1;

  // promotion mask fed to the picker
  always_comb begin
    aged = '0;
    for (int i = 0; i < NUM_REQ; i++)
      aged[i] = int'(age[i]) >= AGE_LIMIT;
  end
`else
  logic unused_age_cfg;
  assign aged           = '0;
  assign unused_age_cfg = (AGE_LIMIT != 0);
`endif

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter: vector table for grant order and
// AR stall, directed sequences for limits, R routing, bad IDs, reset, aging.
module tb_mem_rd_arbiter;

  localparam int NUM_REQ = 3, SLV_ID_W = 4, MAX_OUT = 4, AGE_LIMIT = 4;
  localparam int MST_ID_W = SLV_ID_W + 2;

  logic                        aclk = 1'b0, areset;
  logic [NUM_REQ-1:0]          s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [NUM_REQ*SLV_ID_W-1:0] s_ar_id;
  logic [NUM_REQ*32-1:0]       s_ar_addr;
  logic [NUM_REQ*8-1:0]        s_ar_len;
  logic [NUM_REQ*3-1:0]        s_ar_size;
  logic [NUM_REQ*2-1:0]        s_ar_burst;
  logic [31:0]                 s_r_data, m_ar_addr, m_r_data;
  logic [SLV_ID_W-1:0]         s_r_id;
  logic [1:0]                  s_r_resp, m_ar_burst, m_r_resp;
  logic                        s_r_last, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last, rid_err;
  logic [MST_ID_W-1:0]         m_ar_id, m_r_id;
  logic [7:0]                  m_ar_len;
  logic [2:0]                  m_ar_size;

  mem_rd_arbiter #(.NUM_REQ(NUM_REQ), .SLV_ID_W(SLV_ID_W), .MAX_OUT(MAX_OUT), .AGE_LIMIT(AGE_LIMIT)) dut (
    .aclk(aclk), .areset(areset),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_id(s_r_id),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last), .rid_err(rid_err)
  );

  always #5 aclk = ~aclk;

  int tests = 0, fails = 0;
  logic [SLV_ID_W-1:0] sid   [NUM_REQ];
  logic [31:0]         saddr [NUM_REQ];

  typedef struct packed {
    logic [MST_ID_W-1:0] id;
    logic [31:0]         addr;
    logic [7:0]          len;
  } ar_exp_t;
  ar_exp_t sb[$];
  ar_exp_t mon_e, mon_p;

  typedef struct {
    logic [2:0] sv;
    logic       mr;
    logic [2:0] rdy;
    logic       mvld;
    int         pfx;
  } vec_t;
  vec_t vt[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    areset = 1'b1; s_ar_valid = '0; m_ar_ready = 1'b0; m_r_valid = 1'b0;
    s_r_ready = '0; m_r_last = 1'b0; m_r_id = '0; m_r_data = '0; m_r_resp = '0;
    tick(); tick();
    areset = 1'b0;
  endtask

  // scoreboard: push on requester handshake, pop on memory-side handshake
  always @(negedge aclk) begin
    if (areset) sb.delete();
    else begin
      chk("ar_ready_onehot0", 64'($countones(s_ar_ready) <= 1), 64'(1));
      if (m_ar_valid && m_ar_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          mon_p = sb.pop_front();
          chk("sb_m_ar_id", 64'(m_ar_id), 64'(mon_p.id));
          chk("sb_m_ar_addr", 64'(m_ar_addr), 64'(mon_p.addr));
          chk("sb_m_ar_len", 64'(m_ar_len), 64'(mon_p.len));
        end
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (s_ar_valid[i] && s_ar_ready[i]) begin
          mon_e.id   = {2'(i), sid[i]};
          mon_e.addr = saddr[i];
          mon_e.len  = 8'(i + 1);
          sb.push_back(mon_e);
        end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [MST_ID_W-1:0] eid;
    int b, t, got;

    for (int i = 0; i < NUM_REQ; i++) begin
      sid[i]   = SLV_ID_W'(i * 3 + 5);
      saddr[i] = 32'h1000_0000 * (i + 1) + 32'h40 * i;
      s_ar_id[i*SLV_ID_W +: SLV_ID_W] = sid[i];
      s_ar_addr[i*32 +: 32] = saddr[i];
      s_ar_len[i*8 +: 8]    = 8'(i + 1);
      s_ar_size[i*3 +: 3]   = 3'd2;
      s_ar_burst[i*2 +: 2]  = 2'd1;
    end

    // grant rotation, then a 5-cycle memory stall and a same-cycle reload
    vt[0]  = '{3'b111, 1'b1, 3'b000, 1'b0, 0};
    vt[1]  = '{3'b111, 1'b1, 3'b001, 1'b0, 0};
    vt[2]  = '{3'b111, 1'b1, 3'b010, 1'b1, 0};
    vt[3]  = '{3'b111, 1'b1, 3'b100, 1'b1, 1};
    vt[4]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2};
    vt[5]  = '{3'b111, 1'b1, 3'b010, 1'b1, 0};
    vt[6]  = '{3'b111, 1'b1, 3'b100, 1'b1, 1};
    for (int n = 7; n < 12; n++) vt[n] = '{3'b111, 1'b0, 3'b000, 1'b1, 2};
    vt[12] = '{3'b111, 1'b1, 3'b001, 1'b1, 2};
    vt[13] = '{3'b000, 1'b1, 3'b000, 1'b1, 0};
    vt[14] = '{3'b000, 1'b1, 3'b000, 1'b0, 0};

    do_reset();
    for (int n = 0; n < 15; n++) begin
      s_ar_valid = vt[n].sv;
      m_ar_ready = vt[n].mr;
      @(negedge aclk);
      chk($sformatf("vec%0d_s_ar_ready", n), 64'(s_ar_ready), 64'(vt[n].rdy));
      chk($sformatf("vec%0d_m_ar_valid", n), 64'(m_ar_valid), 64'(vt[n].mvld));
      if (vt[n].mvld) begin
        eid = {2'(vt[n].pfx), sid[vt[n].pfx]};
        chk($sformatf("vec%0d_m_ar_id", n), 64'(m_ar_id), 64'(eid));
        chk($sformatf("vec%0d_m_ar_addr", n), 64'(m_ar_addr), 64'(saddr[vt[n].pfx]));
      end
      tick();
    end

    // asynchronous reset with a loaded slot
    s_ar_valid = 3'b001; m_ar_ready = 1'b0;
    tick();
    chk("slot_loaded", 64'(m_ar_valid), 64'(1));
    #2 areset = 1'b1;
    #1;
    chk("async_rst_m_ar_valid", 64'(m_ar_valid), 64'(0));
    chk("rst_s_ar_ready", 64'(s_ar_ready), 64'(0));
    chk("rst_rid_err", 64'(rid_err), 64'(0));
    tick();
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_no_grant", 64'(s_ar_ready), 64'(0));
    chk("post_rst_m_ar_valid", 64'(m_ar_valid), 64'(0));
    tick();
    @(negedge aclk);
    chk("post_rst_grant0", 64'(s_ar_ready), 64'(3'b001));

    // outstanding limit on req1, others keep flowing
    do_reset();
    s_ar_valid = 3'b010; m_ar_ready = 1'b1;
    tick();
    for (int j = 0; j < MAX_OUT; j++) begin
      @(negedge aclk);
      chk($sformatf("req1_grant%0d", j), 64'(s_ar_ready), 64'(3'b010));
      tick();
    end
    s_ar_valid = 3'b110;
    @(negedge aclk);
    chk("req1_full_req2_wins", 64'(s_ar_ready), 64'(3'b100));
    tick();
    s_ar_valid = 3'b010;
    @(negedge aclk);
    chk("req1_blocked", 64'(s_ar_ready), 64'(0));
    tick();
    m_r_valid = 1'b1; m_r_id = {2'd1, 4'h9}; m_r_last = 1'b1; s_r_ready = 3'b010;
    @(negedge aclk);
    chk("req1_r_valid", 64'(s_r_valid), 64'(3'b010));
    chk("req1_r_id", 64'(s_r_id), 64'(4'h9));
    chk("req1_still_blocked", 64'(s_ar_ready), 64'(0));
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    @(negedge aclk);
    chk("req1_reeligible", 64'(s_ar_ready), 64'(3'b010));
    tick();
    s_ar_valid = '0;

    // 4-beat burst to req2 with toggling ready; count drops once on last
    do_reset();
    s_ar_valid = 3'b100; m_ar_ready = 1'b1;
    tick();
    repeat (MAX_OUT) tick();
    b = 0; t = 0;
    while (b < 4 && t < 20) begin
      m_r_valid = 1'b1; m_r_id = 6'b10_0011; m_r_data = 32'hD000_0000 + b;
      m_r_resp = 2'(b); m_r_last = (b == 3);
      s_r_ready = (t % 2 == 1) ? 3'b111 : 3'b011;
      @(negedge aclk);
      chk("r2_s_r_valid", 64'(s_r_valid), 64'(3'b100));
      chk("r2_m_r_ready", 64'(m_r_ready), 64'(t % 2));
      chk("r2_s_r_id", 64'(s_r_id), 64'(4'h3));
      chk("r2_s_r_data", 64'(s_r_data), 64'(32'hD000_0000 + b));
      chk("r2_s_r_last", 64'(s_r_last), 64'(b == 3));
      chk("r2_ar_blocked", 64'(s_ar_ready), 64'(0));
      chk("r2_rid_err", 64'(rid_err), 64'(0));
      if (t % 2 == 1) b++;
      tick();
      t++;
    end
    chk("r2_beats_done", 64'(b), 64'(4));
    m_r_valid = 1'b0; m_r_last = 1'b0; s_r_ready = '0;
    @(negedge aclk);
    chk("req2_one_slot_free", 64'(s_ar_ready), 64'(3'b100));
    tick();
    @(negedge aclk);
    chk("req2_full_again", 64'(s_ar_ready), 64'(0));
    tick();
    s_ar_valid = '0;

    // unknown requester prefix is sunk and flagged
    m_r_valid = 1'b1; m_r_id = 6'b11_0000; m_r_last = 1'b1; s_r_ready = '0;
    @(negedge aclk);
    chk("bad_id_m_r_ready", 64'(m_r_ready), 64'(1));
    chk("bad_id_no_s_r_valid", 64'(s_r_valid), 64'(0));
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    chk("bad_id_rid_err", 64'(rid_err), 64'(1));
    tick();
    chk("bad_id_rid_err_clear", 64'(rid_err), 64'(0));

    // age promotion: rr_ptr points at req1, both req0/req1 aged
    do_reset();
    tick();
    s_ar_valid = 3'b001; m_ar_ready = 1'b0;
    @(negedge aclk);
    chk("age_setup_grant0", 64'(s_ar_ready), 64'(3'b001));
    tick();
    s_ar_valid = 3'b011;
    for (int j = 0; j < 5; j++) begin
      @(negedge aclk);
      chk("age_stall_no_grant", 64'(s_ar_ready), 64'(0));
      tick();
    end
    m_ar_ready = 1'b1;
    @(negedge aclk);
`ifdef MEM_RD_ARB_AGE_EN
    chk("age_winner", 64'(s_ar_ready), 64'(3'b001));
`else
    chk("rr_winner", 64'(s_ar_ready), 64'(3'b010));
`endif
    tick();

    // req2 must be served within 5 cycles while req0/req1 hammer
    s_ar_valid = 3'b111;
    got = 0;
    for (int c = 0; c < 5 && got == 0; c++) begin
      @(negedge aclk);
      if (s_ar_ready[2]) got = 1;
      tick();
    end
    chk("req2_within_5", 64'(got), 64'(1));

    s_ar_valid = '0;
    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
